// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration frame sequencer.
// Holds the command opcodes, the FSM state encoding and the reset configuration.
// Optional feature macro used by the sequencer: CFG_ERRCLR_EN (error-clear opcode).
package cfg_pkg;

  localparam logic [31:0] DEFAULT_CFG = 32'hBBFC_0000;

  localparam logic [7:0] OP_WRITE  = 8'hA5;  // write config, 4 payload bytes MSB first
  localparam logic [7:0] OP_RESET  = 8'h5A;  // restore DEFAULT_CFG, no payload
  localparam logic [7:0] OP_ERRCLR = 8'hC3;  // clear sticky error (CFG_ERRCLR_EN only)

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PENDING = 2'd2
  } state_t;

endpackage

// File: rtl/cfg_frame_sequencer.sv
// Assembles SPI bytes into a 32-bit shadow configuration and commits it to the
// live configuration at a frame boundary (or right away when COMMIT_ON_FRAME=0).
// Ports: clk/rst_n (sync, active low); rx_valid/rx_byte byte strobe from SPI;
//   ss slave select (1 = transaction ended); frame_start vblank pulse;
//   config_out live config; cfg_updated pulse the cycle after config_out changes;
//   busy (not IDLE); err sticky error; status {err,busy,pending,2'b0,byte_cnt}.
// Optional feature: define CFG_ERRCLR_EN to enable the error-clear opcode.
module cfg_frame_sequencer #(
  parameter logic [31:0] DEFAULT_CFG     = cfg_pkg::DEFAULT_CFG,
  parameter int          COMMIT_ON_FRAME = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        ss,
  input  logic        frame_start,
  output logic [31:0] config_out,
  output logic        cfg_updated,
  output logic        busy,
  output logic        err,
  output logic [7:0]  status
);
  import cfg_pkg::*;

  state_t      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] cfg_q, cfg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        commit;
  logic        commit_d1_q;  // config_out changes one cycle after commit
  logic        upd_q;
  logic [7:0]  status_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (rx_valid) begin
          if (rx_byte == OP_WRITE) begin
            state_d = COLLECT;
`ifdef CFG_ERRCLR_EN
            err_d = 1'b0;
`endif
          end else if (rx_byte == OP_RESET) begin
            shadow_d = DEFAULT_CFG;
            state_d  = PENDING;
          end
`ifdef CFG_ERRCLR_EN
          else if (rx_byte == OP_ERRCLR) begin
            err_d = 1'b0;
          end
`endif
          else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        // Deselect before the fourth byte abandons the partial word.
        if (ss) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = 3'd0;
        end else if (rx_valid) begin
          shadow_d = {shadow_q[23:0], rx_byte};
          if (cnt_q == 3'd3) begin
            state_d = PENDING;
            cnt_d   = 3'd0;
          end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      PENDING: begin
        cnt_d = 3'd0;
        if (rx_valid) err_d = 1'b1;  // overrun: byte is dropped
        if (COMMIT_ON_FRAME == 0 || frame_start) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_d = commit ? shadow_q : cfg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= 32'd0;
      cfg_q       <= DEFAULT_CFG;
      cnt_q       <= 3'd0;
      err_q       <= 1'b0;
      commit_d1_q <= 1'b0;
      upd_q       <= 1'b0;
      status_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      commit_d1_q <= commit;
      upd_q       <= commit_d1_q;
      // Built from next-state values so status lines up with err/busy.
      status_q    <= {err_d, (state_d != IDLE), (state_d == PENDING), 2'b00, cnt_d};
    end
  end

  assign config_out  = cfg_q;
  assign cfg_updated = upd_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign status      = status_q;

endmodule
